// File: rtl/alu_wb_stage.sv
// alu_wb_stage: writeback stage behind the 8-bit ALU.
// Buffers ALU results (result, zero, carry, rd, rd_we, flag_we) in a DEPTH-entry
// FIFO and retires at most one entry per cycle to the register-file write port.
// Retirement also commits Z/C to the architectural flag register.
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_valid/in_ready        push handshake; in_ready = not full (state only)
//   in_result/zero/carry     ALU outputs
//   in_rd/in_rd_we           destination register index and write enable
//   in_flag_we               commit zero/carry on retirement
//   flush                    synchronous discard of all buffered entries
//   rf_we/rf_waddr/rf_wdata  register-file write request (head entry)
//   rf_wack                  register file accepts the write this cycle
//   flag_z/flag_c            architectural flags
//   q_addr/q_hit             pending-write hazard query
//   count                    buffered entry count
module alu_wb_stage #(
  parameter int DATA_W = 8,
  parameter int RA_W   = 3,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_result,
  input  logic                      in_zero,
  input  logic                      in_carry,
  input  logic [RA_W-1:0]           in_rd,
  input  logic                      in_rd_we,
  input  logic                      in_flag_we,
  input  logic                      flush,
  output logic                      rf_we,
  output logic [RA_W-1:0]           rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  input  logic                      rf_wack,
  output logic                      flag_z,
  output logic                      flag_c,
  input  logic [RA_W-1:0]           q_addr,
  output logic                      q_hit,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_result  [DEPTH];
  logic              mem_zero    [DEPTH];
  logic              mem_carry   [DEPTH];
  logic [RA_W-1:0]   mem_rd      [DEPTH];
  logic              mem_rd_we   [DEPTH];
  logic              mem_flag_we [DEPTH];

  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          empty, push, pop;
  logic          head_rd_we;

  assign empty      = (count == '0);
  assign in_ready   = (count != FULL_CNT);
  assign head_rd_we = mem_rd_we[rd_ptr];
  assign push       = in_valid && in_ready;
  // Flags-only entries retire without waiting on the register file.
  assign pop        = !empty && (!head_rd_we || rf_wack);

  assign rf_we    = !empty && head_rd_we;
  assign rf_waddr = mem_rd[rd_ptr];
  assign rf_wdata = mem_result[rd_ptr];

  // Walk live entries from the head; slot i is live when its distance from
  // rd_ptr is below count, so in-cycle pushes are not yet visible.
  always_comb begin
    logic [AW-1:0] idx;
    q_hit = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if (((AW+1)'(i) < count) && mem_rd_we[idx] && (mem_rd[idx] == q_addr))
        q_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_result[i]  <= '0;
        mem_zero[i]    <= 1'b0;
        mem_carry[i]   <= 1'b0;
        mem_rd[i]      <= '0;
        mem_rd_we[i]   <= 1'b0;
        mem_flag_we[i] <= 1'b0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_result[wr_ptr]  <= in_result;
        mem_zero[wr_ptr]    <= in_zero;
        mem_carry[wr_ptr]   <= in_carry;
        mem_rd[wr_ptr]      <= in_rd;
        mem_rd_we[wr_ptr]   <= in_rd_we;
        mem_flag_we[wr_ptr] <= in_flag_we;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (mem_flag_we[rd_ptr]) begin
          flag_z <= mem_zero[rd_ptr];
          flag_c <= mem_carry[rd_ptr];
        end
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Scoreboard bench for alu_wb_stage: stimulus queues expected register-file
// writes; a negedge monitor compares each accepted write against the queue.
module tb_alu_wb_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [7:0] in_result;
  logic       in_zero, in_carry;
  logic [2:0] in_rd;
  logic       in_rd_we, in_flag_we, flush;
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic       rf_wack;
  logic       flag_z, flag_c;
  logic [2:0] q_addr;
  logic       q_hit;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;
  bit toggle_en = 1'b0;

  typedef struct packed {
    logic [2:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t exp_q[$];

  alu_wb_stage #(.DATA_W(8), .RA_W(3), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_zero(in_zero), .in_carry(in_carry),
    .in_rd(in_rd), .in_rd_we(in_rd_we), .in_flag_we(in_flag_we),
    .flush(flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wack(rf_wack),
    .flag_z(flag_z), .flag_c(flag_c),
    .q_addr(q_addr), .q_hit(q_hit),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (toggle_en) rf_wack = ~rf_wack;
  endtask

  task automatic drive(input logic [7:0] res, input logic [2:0] rd, input logic we,
                       input logic fwe, input logic z, input logic c);
    in_result = res; in_rd = rd; in_rd_we = we; in_flag_we = fwe;
    in_zero = z; in_carry = c; in_valid = 1'b1;
  endtask

  // Push one entry, waiting (bounded) for in_ready; queue the expected write.
  task automatic push(input logic [7:0] res, input logic [2:0] rd, input logic we,
                      input logic fwe, input logic z, input logic c);
    int n;
    n = 0;
    drive(res, rd, we, fwe, z, c);
    while (!in_ready && n < 50) begin
      cyc();
      n++;
    end
    check("push_ready", in_ready, 1);
    if (we) exp_q.push_back({rd, res});
    cyc();
    in_valid = 1'b0;
  endtask

  // Monitor: a write is accepted when rf_we && rf_wack at the next edge.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst && !flush && rf_we && rf_wack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=%0h/%0h expected=none", rf_waddr, rf_wdata);
        end else begin
          e = exp_q.pop_front();
          check("rf_write", {21'd0, rf_waddr, rf_wdata}, {21'd0, e.a, e.d});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_result = '0; in_zero = 1'b0; in_carry = 1'b0;
    in_rd = '0; in_rd_we = 1'b0; in_flag_we = 1'b0; flush = 1'b0;
    rf_wack = 1'b0; q_addr = '0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // Reset state
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_rf_we", rf_we, 0);
    check("rst_flags", {flag_z, flag_c}, 2'b00);

    // 1: single write with flags
    rf_wack = 1'b1;
    push(8'h3C, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    check("t1_count", count, 1);
    check("t1_rf_we", rf_we, 1);
    cyc();
    check("t1_flags", {flag_z, flag_c}, 2'b01);
    check("t1_count0", count, 0);

    // 2: fill while register file stalls, 5th push dropped
    rf_wack = 1'b0;
    push(8'hA1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    push(8'hA2, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    push(8'hA3, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    push(8'hA4, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t2_full_count", count, 4);
    check("t2_in_ready", in_ready, 0);
    drive(8'hA5, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    in_valid = 1'b0;
    check("t2_count_after_5th", count, 4);
    check("t2_head_stable", {rf_waddr, rf_wdata}, {3'd1, 8'hA1});
    rf_wack = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    check("t2_drained", count, 0);
    check("t2_flags_kept", {flag_z, flag_c}, 2'b01);

    // 3: flags-only entry ignores rf_wack
    rf_wack = 1'b0;
    push(8'h00, 3'd7, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t3_rf_we", rf_we, 0);
    check("t3_count", count, 1);
    cyc();
    check("t3_count0", count, 0);
    check("t3_flags", {flag_z, flag_c}, 2'b10);

    // 4: hazard query
    q_addr = 3'd5;
    drive(8'h55, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t4_no_inflight_hit", q_hit, 0);
    exp_q.push_back({3'd5, 8'h55});
    cyc();
    push(8'h11, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t4_hit5", q_hit, 1);
    q_addr = 3'd3;
    #1 check("t4_miss3", q_hit, 0);
    q_addr = 3'd5;
    rf_wack = 1'b1;
    cyc();
    check("t4_hit5_gone", q_hit, 0);
    q_addr = 3'd1;
    #1 check("t4_hit1", q_hit, 1);
    cyc();
    check("t4_count0", count, 0);

    // 5: ten pushes with toggling ack, pointers wrap
    rf_wack = 1'b0;
    toggle_en = 1'b1;
    for (int i = 0; i < 10; i++)
      push(8'h80 + 8'(i), 3'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (count != 0 && n < 40) begin
      cyc();
      n++;
    end
    toggle_en = 1'b0;
    rf_wack = 1'b0;
    check("t5_count0", count, 0);
    check("t5_all_written", exp_q.size(), 0);

    // 6: flush beats push and pop
    push(8'hD0, 3'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    push(8'hD1, 3'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    push(8'hD2, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("t6_count3", count, 3);
    drive(8'hEE, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    flush = 1'b1;
    rf_wack = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0; rf_wack = 1'b0;
    exp_q.delete();
    check("t6_flush_count", count, 0);
    check("t6_flush_rf_we", rf_we, 0);
    check("t6_flush_ready", in_ready, 1);
    check("t6_flush_flags", {flag_z, flag_c}, 2'b10);
    cyc();
    check("t6_push_dropped", count, 0);

    // Mid-stream async reset
    push(8'h71, 3'd1, 1'b1, 1'b1, 1'b1, 1'b1);
    push(8'h72, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_count", count, 0);
    check("rst_mid_rf_we", rf_we, 0);
    check("rst_mid_flags", {flag_z, flag_c}, 2'b00);
    exp_q.delete();
    cyc();
    rst = 1'b0;
    cyc();
    check("rst_mid_ready", in_ready, 1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
